// File: rtl/argmax_readout_if.sv
// Score stream in, winning-class result out, plus the synchronous flush.
interface argmax_readout_if #(
  parameter int IDX_W = 4
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [15:0]      out_max;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_max
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_max
  );
endinterface

// File: rtl/argmax_readout.sv
// Streaming winner-take-all: scans N_CLASSES scores per frame and holds
// the index and value of the first maximum until the consumer takes it.
module argmax_readout #(
  parameter int N_CLASSES = 10,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  argmax_readout_if.slave  bus
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);

  typedef enum logic {SCAN = 1'b0, HOLD = 1'b1} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_max;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_idx;
  logic [15:0]      r_out_max;

  logic             w_gt;
  logic             w_accept;
  logic [15:0]      w_nmax;
  logic [IDX_W-1:0] w_nidx;

  comp_16bit u_comp (
    .a  (bus.in_data),
    .b  (r_max),
    .gt (w_gt)
  );

  assign bus.in_ready  = rst_n & (r_state == SCAN);
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_max   = r_out_max;
  assign w_accept      = bus.in_valid & bus.in_ready;

  // Running maximum including the current beat; first beat loads unconditionally
  always_comb begin
    w_nmax = r_max;
    w_nidx = r_idx;
    if (r_cnt == '0) begin
      w_nmax = bus.in_data;
      w_nidx = '0;
    end else if (w_gt) begin
      w_nmax = bus.in_data;
      w_nidx = r_cnt;
    end
  end

  // Frame scan / result hold state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SCAN;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_max       <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_max   <= '0;
    end else if (bus.flush) begin
      r_state     <= SCAN;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_max       <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_max   <= '0;
    end else begin
      case (r_state)
        SCAN: begin
          if (w_accept) begin
            r_max <= w_nmax;
            r_idx <= w_nidx;
            if (r_cnt == LAST) begin
              r_state     <= HOLD;
              r_cnt       <= '0;
              r_out_valid <= 1'b1;
              r_out_idx   <= w_nidx;
              r_out_max   <= w_nmax;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= SCAN;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end
endmodule

// Unsigned 16-bit magnitude compare built from four 4-bit slices;
// slice results ripple from LSB to MSB so a higher equal slice defers down.
module comp_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt
);
  logic [3:0] w_sl_gt;
  logic [3:0] w_sl_eq;
  logic       w_acc;

  // Per-slice compare, then cascade: a higher slice overrides unless equal
  always_comb begin
    w_sl_gt = '0;
    w_sl_eq = '0;
    w_acc   = 1'b0;
    for (int unsigned s = 0; s < 4; s++) begin
      w_sl_gt[s] = a[s*4 +: 4] > b[s*4 +: 4];
      w_sl_eq[s] = a[s*4 +: 4] == b[s*4 +: 4];
    end
    for (int unsigned s = 0; s < 4; s++) begin
      w_acc = w_sl_gt[s] | (w_sl_eq[s] & w_acc);
    end
  end

  assign gt = w_acc;
endmodule
